sha256_msg_padder: RTL and testbench

- Upstream feeder for the SHA-256 compression core.
- Reads a word-aligned message from the shared synchronous memory port and applies standard SHA-256 padding: 0x80000000 marker, zero fill, then a 64-bit big-endian bit length.
- Emits complete 512-bit blocks over a valid/ready handshake, with first/last tags, so the core never computes padding or addresses itself.

---
 rtl/sha256_pkg.sv | 16 +
 rtl/sha256_msg_padder_if.sv | 13 +
 rtl/sha256_blk_buf.sv | 33 +++
 rtl/sha256_msg_padder.sv | 129 ++++++++++++
 tb/tb_sha256_msg_padder.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants used by the message padder and its block buffer.
package sha256_pkg;

  typedef logic [511:0] sha256_block_t;

  localparam int          SHA256_WORDS_PER_BLOCK = 16;
  localparam logic [31:0] SHA256_PAD_WORD        = 32'h8000_0000;

  typedef enum logic [1:0] {
    PAD_IDLE,
    PAD_FILL,
    PAD_EMIT,
    PAD_DONE
  } pad_state_t;

endpackage

// File: rtl/sha256_msg_padder_if.sv
// Block stream from the padder to the compression core (valid/ready with first/last tags).
interface sha256_msg_padder_if;

  logic                      blk_valid;
  logic                      blk_ready;
  sha256_pkg::sha256_block_t blk_data;
  logic                      blk_first;
  logic                      blk_last;

  modport master (output blk_valid, blk_data, blk_first, blk_last, input blk_ready);
  modport slave  (input blk_valid, blk_data, blk_first, blk_last, output blk_ready);

endinterface

// File: rtl/sha256_blk_buf.sv
// 16 x 32-bit write-indexed block buffer; word 0 appears in the top bits of the packed output.
module sha256_blk_buf
  import sha256_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clear,
  input  logic          we,
  input  logic [3:0]    widx,
  input  logic [31:0]   wdata,
  output sha256_block_t data
);

  logic [31:0] words [SHA256_WORDS_PER_BLOCK];

  // NOTE: the storage is reset (not left uninitialised) because blk_data must read zero out of reset;
  // sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SHA256_WORDS_PER_BLOCK; i++) words[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < SHA256_WORDS_PER_BLOCK; i++) words[i] <= '0;
    end else if (we) begin
      words[widx] <= wdata;
    end
  end

  always_comb begin
    data = '0;
    for (int i = 0; i < SHA256_WORDS_PER_BLOCK; i++) data[511-32*i -: 32] = words[i];
  end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a word-aligned message from memory and emits SHA-256 padded 512-bit blocks.
// Optional build macro SHA256_PAD_BSWAP_EN byte-reverses every word fetched from memory.
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    message_addr,
  input  logic [LEN_W-1:0]     msg_words,
  output logic                 mem_clk,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [31:0]          mem_read_data,
  sha256_msg_padder_if.master  blk,
  output logic                 done
);

  localparam int IDX_W = LEN_W + 1;  // stream index reaches 16B-1, one bit beyond N
  localparam int BLK_W = LEN_W - 3;

  pad_state_t        state, state_nx;
  logic [ADDR_W-1:0] base_q, addr_q;
  logic [LEN_W-1:0]  n_q;
  logic [BLK_W-1:0]  blk_idx, last_blk;
  logic [4:0]        issue_cnt;
  logic              wr_pend, wr_from_mem;
  logic [3:0]        wr_slot;
  logic [31:0]       wr_const, stream_const, mem_word, len_word;
  logic [IDX_W-1:0]  j, n_ext;
  logic              issuing, rd_mem, fill_done, handshake, is_last, launch;

  assign mem_clk = clk;
  assign mem_we  = 1'b0;

`ifdef SHA256_PAD_BSWAP_EN
  assign mem_word = {mem_read_data[7:0], mem_read_data[15:8], mem_read_data[23:16], mem_read_data[31:24]};
`else
  assign mem_word = mem_read_data;
`endif

  assign n_ext     = {1'b0, n_q};
  assign last_blk  = BLK_W'((n_ext + IDX_W'(2)) >> 4);
  assign len_word  = 32'({n_q, 5'd0});
  assign j         = {blk_idx, issue_cnt[3:0]};
  assign launch    = (state == PAD_IDLE) && start;
  assign issuing   = (state == PAD_FILL) && !issue_cnt[4];
  assign rd_mem    = issuing && (j < n_ext);
  assign fill_done = (state == PAD_FILL) && wr_pend && (wr_slot == 4'd15);
  assign is_last   = (blk_idx == last_blk);
  assign handshake = (state == PAD_EMIT) && blk.blk_ready;

  // Address is held after the last read so it stays frozen while a block waits for the consumer.
  assign mem_addr = rd_mem ? base_q + ADDR_W'(j) : addr_q;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    stream_const = '0;
    if (j == n_ext)                               stream_const = SHA256_PAD_WORD;
    else if (is_last && issue_cnt[3:0] == 4'd15)  stream_const = len_word;
  end

  always_comb begin
    state_nx = state;
    case (state)
      PAD_IDLE: if (start)     state_nx = PAD_FILL;
      PAD_FILL: if (fill_done) state_nx = PAD_EMIT;
      PAD_EMIT: if (blk.blk_ready) state_nx = is_last ? PAD_DONE : PAD_FILL;
      PAD_DONE: state_nx = PAD_IDLE;
      default:  state_nx = PAD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= PAD_IDLE;
    else          state <= state_nx;
  end

  // Every word, memory or constant, passes one register stage so the buffer needs a single write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q      <= '0;
      addr_q      <= '0;
      n_q         <= '0;
      blk_idx     <= '0;
      issue_cnt   <= '0;
      wr_pend     <= 1'b0;
      wr_from_mem <= 1'b0;
      wr_slot     <= '0;
      wr_const    <= '0;
    end else begin
      addr_q      <= mem_addr;
      wr_pend     <= issuing;
      wr_from_mem <= rd_mem;
      wr_slot     <= issue_cnt[3:0];
      wr_const    <= stream_const;
      if (launch) begin
        base_q    <= message_addr;
        n_q       <= msg_words;
        blk_idx   <= '0;
        issue_cnt <= '0;
      end else if (issuing) begin
        issue_cnt <= issue_cnt + 5'd1;
      end else if (handshake && !is_last) begin
        blk_idx   <= blk_idx + BLK_W'(1);
        issue_cnt <= '0;
      end
    end
  end

  sha256_blk_buf u_buf (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (launch),
    .we      (wr_pend),
    .widx    (wr_slot),
    .wdata   (wr_from_mem ? mem_word : wr_const),
    .data    (blk.blk_data)
  );

  assign blk.blk_valid = (state == PAD_EMIT);
  assign blk.blk_first = (state == PAD_EMIT) && (blk_idx == '0);
  assign blk.blk_last  = (state == PAD_EMIT) && is_last;
  assign done          = (state == PAD_DONE);

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder with a synchronous-read memory model.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] message_addr = '0;
  logic [15:0] msg_words = '0;
  logic        mem_clk, mem_we, done;
  logic [15:0] mem_addr;
  logic [31:0] mem_read_data;
  logic [31:0] mem [65536];

  int n_cmp = 0;
  int n_fail = 0;
  int lat;
  logic [511:0] e0, e1;

  sha256_msg_padder_if bif ();

  sha256_msg_padder #(.ADDR_W(16), .LEN_W(16)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .message_addr  (message_addr),
    .msg_words     (msg_words),
    .mem_clk       (mem_clk),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_read_data (mem_read_data),
    .blk           (bif.master),
    .done          (done)
  );

  always #5 clk = ~clk;

  always @(posedge mem_clk) mem_read_data <= mem[mem_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] put(input logic [511:0] b, input int i, input logic [31:0] v);
    logic [511:0] r;
    r = b;
    r[511-32*i -: 32] = v;
    return r;
  endfunction

  function automatic logic [31:0] expw(input logic [31:0] x);
`ifdef SHA256_PAD_BSWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  task automatic start_msg(input logic [15:0] a, input logic [15:0] n);
    @(negedge clk);
    message_addr = a;
    msg_words    = n;
    start        = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_block(input string tag, input logic [511:0] exp, input logic ef, input logic el,
                           input int hold, input logic [15:0] hold_addr, output int l);
    int cyc;
    cyc = 0;
    while (bif.blk_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    l = cyc;
    check({tag, " valid"}, bif.blk_valid, 1'b1);
    check({tag, " data"}, bif.blk_data, exp);
    check({tag, " first"}, bif.blk_first, ef);
    check({tag, " last"}, bif.blk_last, el);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({tag, " hold valid"}, bif.blk_valid, 1'b1);
      check({tag, " hold data"}, bif.blk_data, exp);
      check({tag, " hold addr"}, mem_addr, hold_addr);
    end
    bif.blk_ready = 1'b1;
    @(negedge clk);
    bif.blk_ready = 1'b0;
    check({tag, " valid drop"}, bif.blk_valid, 1'b0);
  endtask

  task automatic check_done(input string tag);
    check({tag, " done pulse"}, done, 1'b1);
    @(negedge clk);
    check({tag, " done clear"}, done, 1'b0);
  endtask

  initial begin
    bif.blk_ready = 1'b0;
    for (int i = 0; i < 65536; i++) mem[i] = 32'(i + 1);
    mem[16'h0200] = 32'h1122_3344;

    // Reset state
    @(negedge clk);
    check("rst valid", bif.blk_valid, 1'b0);
    check("rst first", bif.blk_first, 1'b0);
    check("rst last", bif.blk_last, 1'b0);
    check("rst done", done, 1'b0);
    check("rst mem_we", mem_we, 1'b0);
    check("rst mem_addr", mem_addr, 16'h0000);
    check("rst data", bif.blk_data, 512'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // N=0: marker then zeros, length 0
    start_msg(16'h0000, 16'd0);
    e0 = put(512'h0, 0, 32'h8000_0000);
    run_block("n0", e0, 1'b1, 1'b1, 0, 16'h0, lat);
    check("n0 mem_addr idle", mem_addr, 16'h0000);
    check_done("n0");

    // N=20: block 0 held off for 10 cycles, then block 1 with the tail and length
    start_msg(16'h0000, 16'd20);
    e0 = '0;
    for (int i = 0; i < 16; i++) e0 = put(e0, i, expw(32'(i + 1)));
    run_block("n20 b0", e0, 1'b1, 1'b0, 10, 16'h000F, lat);
    check("n20 fill latency", lat, 17);
    e1 = '0;
    for (int i = 0; i < 4; i++) e1 = put(e1, i, expw(32'(17 + i)));
    e1 = put(e1, 4, 32'h8000_0000);
    e1 = put(e1, 15, 32'h0000_0280);
    run_block("n20 b1", e1, 1'b0, 1'b1, 0, 16'h0, lat);
    check_done("n20");

    // N=13: exactly fits in one block
    start_msg(16'h0100, 16'd13);
    e0 = '0;
    for (int i = 0; i < 13; i++) e0 = put(e0, i, expw(32'h101 + 32'(i)));
    e0 = put(e0, 13, 32'h8000_0000);
    e0 = put(e0, 15, 32'h0000_01A0);
    run_block("n13", e0, 1'b1, 1'b1, 0, 16'h0, lat);
    check_done("n13");

    // N=14: marker in block 0 word 14, length spills into block 1
    start_msg(16'h0100, 16'd14);
    e0 = '0;
    for (int i = 0; i < 14; i++) e0 = put(e0, i, expw(32'h101 + 32'(i)));
    e0 = put(e0, 14, 32'h8000_0000);
    run_block("n14 b0", e0, 1'b1, 1'b0, 0, 16'h0, lat);
    e1 = put(512'h0, 15, 32'h0000_01C0);
    run_block("n14 b1", e1, 1'b0, 1'b1, 0, 16'h0, lat);
    check_done("n14");

    // Address wrap: FFFE, FFFF, 0000
    start_msg(16'hFFFE, 16'd3);
    e0 = '0;
    e0 = put(e0, 0, expw(32'h0000_FFFF));
    e0 = put(e0, 1, expw(32'h0001_0000));
    e0 = put(e0, 2, expw(32'h0000_0001));
    e0 = put(e0, 3, 32'h8000_0000);
    e0 = put(e0, 15, 32'h0000_0060);
    run_block("wrap", e0, 1'b1, 1'b1, 0, 16'h0, lat);
    check_done("wrap");

    // Reset in the middle of FILL abandons the message
    start_msg(16'h0000, 16'd20);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst valid", bif.blk_valid, 1'b0);
    check("midrst first", bif.blk_first, 1'b0);
    check("midrst last", bif.blk_last, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst mem_addr", mem_addr, 16'h0000);
    check("midrst data", bif.blk_data, 512'h0);
    @(negedge clk);
    reset_n = 1'b1;
    start_msg(16'h0000, 16'd0);
    e0 = put(512'h0, 0, 32'h8000_0000);
    run_block("postrst n0", e0, 1'b1, 1'b1, 0, 16'h0, lat);
    check_done("postrst");

    // Single word: swapped only when the byte-swap build option is on
    start_msg(16'h0200, 16'd1);
    e0 = '0;
    e0 = put(e0, 0, expw(32'h1122_3344));
    e0 = put(e0, 1, 32'h8000_0000);
    e0 = put(e0, 15, 32'h0000_0020);
    run_block("n1 swap", e0, 1'b1, 1'b1, 0, 16'h0, lat);
    check_done("n1");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
